display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner_if.sv | 24 ++
 rtl/display_scanner.sv | 71 +++++++
 tb/tb_display_scanner.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/display_scanner_if.sv
// Display scanner bus: digit data, blanking and scan controls in; digit drive and frame status out.
interface display_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    logic                          en;
    logic                          load;
    logic [4*NUM_DIGITS-1:0]       data_in;
    logic [NUM_DIGITS-1:0]         blank_mask;
    logic [3:0]                    digit_code;
    logic [NUM_DIGITS-1:0]         anode;
    logic [$clog2(NUM_DIGITS)-1:0] digit_idx;
    logic                          pending;
    logic                          frame_done;

    modport master (
        output en, load, data_in, blank_mask,
        input  digit_code, anode, digit_idx, pending, frame_done
    );

    modport slave (
        input  en, load, data_in, blank_mask,
        output digit_code, anode, digit_idx, pending, frame_done
    );
endinterface

// File: rtl/display_scanner.sv
// Multiplexed seven-segment scanner with frame-synchronous double-buffered digit data.
// digit_code/anode follow digit_idx with zero latency; no backpressure, load is accepted every cycle.
module display_scanner #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    display_scanner_if.slave  bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int PW = $clog2(REFRESH_DIV);

    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           digit_idx;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    pending;
    logic                    frame_done;

    logic tick;
    logic boundary;
    logic blanked;

    assign tick     = bus.en && (prescaler == PW'(REFRESH_DIV - 1));
    assign boundary = tick && (digit_idx == IW'(NUM_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler  <= '0;
            digit_idx  <= '0;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;

            if (bus.en) begin
                if (tick) begin
                    prescaler <= '0;
                    digit_idx <= boundary ? '0 : digit_idx + 1'b1;
                end else begin
                    prescaler <= prescaler + 1'b1;
                end
            end

            // active only ever changes on a frame boundary, so a frame never mixes old and new data
            if (bus.load && boundary) begin
                shadow  <= bus.data_in;
                active  <= bus.data_in;
                pending <= 1'b0;
            end else if (bus.load) begin
                shadow  <= bus.data_in;
                pending <= 1'b1;
            end else if (boundary && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end
        end
    end

    assign blanked = !bus.en || bus.blank_mask[digit_idx];

    // Nibbles pass through untouched; sign handling belongs to the segment decoder.
    assign bus.digit_code = blanked ? 4'b0000 : active[{digit_idx, 2'b00} +: 4];
    assign bus.anode      = blanked ? '0 : (NUM_DIGITS'(1) << digit_idx);
    assign bus.digit_idx  = digit_idx;
    assign bus.pending    = pending;
    assign bus.frame_done = frame_done;
endmodule

// File: tb/tb_display_scanner.sv
// Directed checks of the display scanner with NUM_DIGITS=4, REFRESH_DIV=4.
module tb_display_scanner;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    display_scanner_if #(.NUM_DIGITS(4)) bus ();

    display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        en;
        logic        load;
        logic [15:0] data;
        logic [3:0]  blank;
        logic [3:0]  anode;
        logic [3:0]  code;
        logic [1:0]  idx;
        logic        pend;
        logic        fd;
    } vec_t;

    vec_t       tbl [48];
    logic [3:0] scan_nib [4] = '{4'h1, 4'h3, 4'hA, 4'h7};
    logic [3:0] tear_nib [4] = '{4'h1, 4'h3, 4'hA, 4'h7};
    logic [3:0] coin_nib [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] anode, input logic [3:0] code,
                           input logic [1:0] idx, input logic pend, input logic fd);
        chk({tag, ".anode"},      32'(bus.anode),      32'(anode));
        chk({tag, ".digit_code"}, 32'(bus.digit_code), 32'(code));
        chk({tag, ".digit_idx"},  32'(bus.digit_idx),  32'(idx));
        chk({tag, ".pending"},    32'(bus.pending),    32'(pend));
        chk({tag, ".frame_done"}, 32'(bus.frame_done), 32'(fd));
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Basic scan of 16'h7A31 for three frames, the third with digit 2 blanked.
        for (int c = 0; c < 48; c++) begin
            int         ix;
            logic [3:0] nib;
            logic [3:0] bm;
            ix  = (c / 4) % 4;
            nib = (c < 16) ? 4'h0 : scan_nib[ix];
            bm  = (c >= 32) ? 4'b0100 : 4'b0000;
            tbl[c].en    = 1'b1;
            tbl[c].load  = (c == 0);
            tbl[c].data  = 16'h7A31;
            tbl[c].blank = bm;
            tbl[c].anode = bm[ix] ? 4'b0000 : 4'(1 << ix);
            tbl[c].code  = bm[ix] ? 4'h0 : nib;
            tbl[c].idx   = 2'(ix);
            tbl[c].pend  = (c >= 1 && c < 16);
            tbl[c].fd    = (c == 16 || c == 32);
        end

        rst = 1'b1;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.data_in = 16'h0;
        bus.blank_mask = 4'h0;
        step(2);
        rst = 1'b0;
        #1;
        chk_all("reset_en0", 4'b0000, 4'h0, 2'd0, 1'b0, 1'b0);
        step(1);
        #1;
        chk("reset_en0_hold.idx", 32'(bus.digit_idx), 32'd0);

        for (int c = 0; c < 48; c++) begin
            bus.en         = tbl[c].en;
            bus.load       = tbl[c].load;
            bus.data_in    = tbl[c].data;
            bus.blank_mask = tbl[c].blank;
            #1;
            chk_all($sformatf("scan[%0d]", c), tbl[c].anode, tbl[c].code, tbl[c].idx,
                    tbl[c].pend, tbl[c].fd);
            @(posedge clk);
            #1;
        end

        // No tearing: load 16'hFFFF at digit 1 of a frame.
        bus.load = 1'b0;
        bus.blank_mask = 4'h0;
        #1;
        chk("tear_start.frame_done", 32'(bus.frame_done), 32'd1);
        step(4);
        chk("tear_load_at.idx", 32'(bus.digit_idx), 32'd1);
        bus.load = 1'b1;
        bus.data_in = 16'hFFFF;
        step(1);
        bus.load = 1'b0;
        for (int c = 53; c < 64; c++) begin
            #1;
            chk($sformatf("tear[%0d].code", c), 32'(bus.digit_code), 32'(tear_nib[(c - 48) / 4]));
            chk($sformatf("tear[%0d].pending", c), 32'(bus.pending), 32'd1);
            step(1);
        end
        #1;
        chk_all("tear_boundary", 4'b0001, 4'hF, 2'd0, 1'b0, 1'b1);

        // Load coinciding with the frame boundary tick.
        step(15);
        chk("coin_at.idx", 32'(bus.digit_idx), 32'd3);
        bus.load = 1'b1;
        bus.data_in = 16'h1234;
        step(1);
        bus.load = 1'b0;
        #1;
        chk_all("coin_boundary", 4'b0001, 4'h4, 2'd0, 1'b0, 1'b1);
        for (int k = 1; k < 4; k++) begin
            step(4);
            chk($sformatf("coin_digit%0d.code", k), 32'(bus.digit_code), 32'(coin_nib[k]));
            chk($sformatf("coin_digit%0d.pending", k), 32'(bus.pending), 32'd0);
        end

        // Enable freeze at idx 3, prescaler 2, for 10 cycles.
        step(2);
        bus.en = 1'b0;
        #1;
        chk_all("freeze_start", 4'b0000, 4'h0, 2'd3, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1);
            chk($sformatf("freeze[%0d].anode", i), 32'(bus.anode), 32'd0);
            chk($sformatf("freeze[%0d].idx", i), 32'(bus.digit_idx), 32'd3);
            chk($sformatf("freeze[%0d].frame_done", i), 32'(bus.frame_done), 32'd0);
        end
        step(1);
        bus.en = 1'b1;
        #1;
        chk_all("resume_p2", 4'b1000, 4'h1, 2'd3, 1'b0, 1'b0);
        step(1);
        chk_all("resume_p3", 4'b1000, 4'h1, 2'd3, 1'b0, 1'b0);
        step(1);
        chk_all("resume_wrap", 4'b0001, 4'h4, 2'd0, 1'b0, 1'b1);

        // Reset mid-frame with a transfer pending and a load on the reset cycle.
        bus.load = 1'b1;
        bus.data_in = 16'h5555;
        step(1);
        bus.load = 1'b0;
        chk("rst_pre.pending", 32'(bus.pending), 32'd1);
        step(7);
        chk("rst_pre.idx", 32'(bus.digit_idx), 32'd2);
        rst = 1'b1;
        bus.load = 1'b1;
        bus.data_in = 16'h9999;
        step(1);
        rst = 1'b0;
        bus.load = 1'b0;
        #1;
        chk_all("rst_after", 4'b0001, 4'h0, 2'd0, 1'b0, 1'b0);
        step(4);
        chk_all("rst_digit1", 4'b0010, 4'h0, 2'd1, 1'b0, 1'b0);
        step(12);
        chk_all("rst_next_frame", 4'b0001, 4'h0, 2'd0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
